// File: rtl/dmem_defs.sv
// Shared definitions for the data memory arbiter:
// FSM encodings, default widths and the wait-counter width helper.
package dmem_defs;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HOST_DATA = 2'd1,
    HOST_ACK  = 2'd2
  } state_e;

  function automatic int cnt_width(int max_wait);
    return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Pipeline, host and memory-side signals of the data memory arbiter.
// slave = arbiter side, master = the surrounding pipeline/host/memory.
interface dmem_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 8
);

  logic          pipe_mem_req;
  logic          pipe_wen;
  logic [DW-1:0] pipe_addr;
  logic [DW-1:0] pipe_wdata;
  logic [DW-1:0] pipe_rdata;
  logic          pipe_stall;
  logic          host_req;
  logic          host_wen;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_ack;
  logic [DW-1:0] host_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          mem_wen;
  logic [DW-1:0] mem_dout;

  modport slave (
    input  pipe_mem_req, pipe_wen, pipe_addr, pipe_wdata,
    input  host_req, host_wen, host_addr, host_wdata,
    input  mem_dout,
    output pipe_rdata, pipe_stall, host_ack, host_rdata,
    output mem_addr, mem_din, mem_wen
  );

  modport master (
    output pipe_mem_req, pipe_wen, pipe_addr, pipe_wdata,
    output host_req, host_wen, host_addr, host_wdata,
    output mem_dout,
    input  pipe_rdata, pipe_stall, host_ack, host_rdata,
    input  mem_addr, mem_din, mem_wen
  );

endinterface

// File: rtl/dmem_starve_cnt.sv
// Saturating count of IDLE cycles a host request has been denied.
module dmem_starve_cnt
  import dmem_defs::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int W = cnt_width(MAX_WAIT);
  localparam logic [W-1:0] MAX = W'(MAX_WAIT);

  logic [W-1:0] cnt_q, cnt_d;

  assign at_max = (cnt_q == MAX);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && !at_max)
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the MEM stage and the
// host port; the pipeline wins until the host has waited MAX_WAIT cycles.
module dmem_arbiter
  import dmem_defs::*;
#(
  parameter int data_width = DATA_WIDTH,
  parameter int addr_width = ADDR_WIDTH,
  parameter int MAX_WAIT   = 4
) (
  input logic         clk,
  input logic         rst_n,
  dmem_arbiter_if.slave bus
);

  state_e                  state_q, state_d;
  logic                    ack_q, ack_d;
  logic [data_width-1:0]   rdata_q, rdata_d;
  logic                    hwen_q, hwen_d;
  logic                    at_max;
  logic                    grant;
  logic                    idle;
  logic [addr_width-1:0]   pipe_a;

  assign idle   = (state_q == IDLE);
  assign pipe_a = bus.pipe_addr[addr_width-1:0];

  // Gated by rst_n so nothing reaches the memory while held in reset.
  assign grant = rst_n & idle & bus.host_req &
                 (~bus.pipe_mem_req | at_max);

  dmem_starve_cnt #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (idle & bus.host_req & ~grant),
    .clr    (grant | (idle & ~bus.host_req)),
    .at_max (at_max)
  );

  always_comb begin
    bus.mem_addr   = pipe_a;
    bus.mem_din    = bus.pipe_wdata;
    bus.mem_wen    = rst_n & bus.pipe_mem_req & bus.pipe_wen;
    bus.pipe_stall = 1'b0;
    unique case (1'b1)
      grant: begin
        bus.mem_addr   = bus.host_addr;
        bus.mem_din    = bus.host_wdata;
        bus.mem_wen    = bus.host_wen;
        bus.pipe_stall = bus.pipe_mem_req;
      end
      default: ;
    endcase
  end

  assign bus.pipe_rdata = bus.mem_dout;
  assign bus.host_ack   = ack_q;
  assign bus.host_rdata = rdata_q;

  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    rdata_d = rdata_q;
    hwen_d  = hwen_q;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          state_d = HOST_DATA;
          hwen_d  = bus.host_wen;
        end
      end
      HOST_DATA: begin
        state_d = HOST_ACK;
        ack_d   = 1'b1;
        if (!hwen_q) rdata_d = bus.mem_dout;
      end
      HOST_ACK: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      hwen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      hwen_q  <= hwen_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: expected host acks and pipeline
// loads are queued by the stimulus and checked by a negedge monitor.
module tb_dmem_arbiter;
  import dmem_defs::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.DW(32), .AW(8)) bus ();

  dmem_arbiter #(
    .data_width (32),
    .addr_width (8),
    .MAX_WAIT   (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (bus.mem_wen) mem[bus.mem_addr] <= bus.mem_din;
    bus.mem_dout <= mem[bus.mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    string       name;
  } exp_t;

  exp_t ackq[$];
  exp_t pipeq[$];
  exp_t me;
  int nvec = 0;
  int nerr = 0;
  logic [31:0] last_rd = 32'h0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(int c, logic [31:0] d, string n);
    exp_t e;
    e.cyc  = c;
    e.data = d;
    e.name = n;
    return e;
  endfunction

  always @(negedge clk) begin
    if (bus.host_ack === 1'b1) begin
      if (ackq.size() == 0) begin
        chk("unexpected_ack", 32'd1, 32'd0);
      end else begin
        me = ackq.pop_front();
        chk({me.name, "_ack_cycle"}, 32'(cyc), 32'(me.cyc));
        chk({me.name, "_rdata"}, bus.host_rdata, me.data);
      end
    end else if (ackq.size() > 0 && cyc > ackq[0].cyc) begin
      me = ackq.pop_front();
      chk({me.name, "_ack_missing"}, 32'd0, 32'd1);
    end
    if (pipeq.size() > 0 && cyc >= pipeq[0].cyc) begin
      me = pipeq.pop_front();
      if (cyc == me.cyc)
        chk({me.name, "_pipe_rdata"}, bus.pipe_rdata, me.data);
      else
        chk({me.name, "_pipe_missed"}, 32'd0, 32'd1);
    end
  end

  initial begin
    int c;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    bus.pipe_mem_req = 1'b1;
    bus.pipe_wen     = 1'b1;
    bus.pipe_addr    = 32'h0;
    bus.pipe_wdata   = 32'h0;
    bus.host_req     = 1'b1;
    bus.host_wen     = 1'b1;
    bus.host_addr    = 8'h0;
    bus.host_wdata   = 32'h0;

    #12;
    chk("reset_mem_wen", 32'(bus.mem_wen), 32'd0);
    chk("reset_stall", 32'(bus.pipe_stall), 32'd0);
    chk("reset_ack", 32'(bus.host_ack), 32'd0);
    chk("reset_rdata", bus.host_rdata, 32'h0);

    tick();
    bus.pipe_mem_req = 1'b0;
    bus.pipe_wen     = 1'b0;
    bus.host_req     = 1'b0;
    bus.host_wen     = 1'b0;
    rst_n            = 1'b1;
    tick();

    // host write, pipe idle; request then held through the ack
    c = cyc;
    bus.host_req   = 1'b1;
    bus.host_wen   = 1'b1;
    bus.host_addr  = 8'h10;
    bus.host_wdata = 32'hDEADBEEF;
    ackq.push_back(mk(c + 2, last_rd, "hwr"));
    @(negedge clk);
    chk("hwr_mem_wen", 32'(bus.mem_wen), 32'd1);
    chk("hwr_mem_addr", 32'(bus.mem_addr), 32'h10);
    chk("hwr_mem_din", bus.mem_din, 32'hDEADBEEF);
    chk("hwr_stall", 32'(bus.pipe_stall), 32'd0);
    tick();
    @(negedge clk);
    chk("hdata_stall", 32'(bus.pipe_stall), 32'd0);
    tick();
    @(negedge clk);
    chk("held_no_regrant_wen", 32'(bus.mem_wen), 32'd0);
    chk("held_no_regrant_addr", 32'(bus.mem_addr), 32'h0);
    tick();
    bus.host_wen = 1'b0;
    ackq.push_back(mk(c + 5, 32'hDEADBEEF, "hrd"));
    @(negedge clk);
    chk("regrant_addr", 32'(bus.mem_addr), 32'h10);
    chk("regrant_wen", 32'(bus.mem_wen), 32'd0);
    tick();
    tick();
    tick();
    bus.host_req = 1'b0;
    last_rd = 32'hDEADBEEF;
    tick();

    // starvation: pipe always requesting, host held for two accesses
    bus.pipe_mem_req = 1'b1;
    bus.pipe_wen     = 1'b0;
    bus.pipe_addr    = 32'h30;
    bus.host_req     = 1'b1;
    bus.host_wen     = 1'b0;
    bus.host_addr    = 8'h10;
    for (int r = 0; r < 2; r++) begin
      c = cyc;
      ackq.push_back(mk(c + 6, 32'hDEADBEEF, "starve"));
      for (int k = 0; k < 7; k++) begin
        @(negedge clk);
        chk("starve_stall", 32'(bus.pipe_stall), (k == 4) ? 32'd1 : 32'd0);
        chk("starve_addr", 32'(bus.mem_addr), (k == 4) ? 32'h10 : 32'h30);
        tick();
      end
    end
    bus.host_req     = 1'b0;
    bus.pipe_mem_req = 1'b0;
    tick();

    // pipeline store with address wrap, then load it back
    bus.pipe_mem_req = 1'b1;
    bus.pipe_wen     = 1'b1;
    bus.pipe_addr    = 32'h104;
    bus.pipe_wdata   = 32'h12345678;
    @(negedge clk);
    chk("pst_mem_wen", 32'(bus.mem_wen), 32'd1);
    chk("pst_mem_addr", 32'(bus.mem_addr), 32'h04);
    chk("pst_mem_din", bus.mem_din, 32'h12345678);
    tick();
    bus.pipe_wen  = 1'b0;
    bus.pipe_addr = 32'h04;
    pipeq.push_back(mk(cyc + 1, 32'h12345678, "pld"));
    @(negedge clk);
    chk("pld_mem_wen", 32'(bus.mem_wen), 32'd0);
    tick();
    bus.pipe_mem_req = 1'b0;
    tick();

    // reset asserted in HOST_DATA abandons the access
    bus.host_req   = 1'b1;
    bus.host_wen   = 1'b1;
    bus.host_addr  = 8'h20;
    bus.host_wdata = 32'hA5A5A5A5;
    @(negedge clk);
    chk("rst_grant_wen", 32'(bus.mem_wen), 32'd1);
    tick();
    bus.pipe_mem_req = 1'b1;
    bus.pipe_wen     = 1'b1;
    rst_n            = 1'b0;
    #1;
    chk("async_mem_wen", 32'(bus.mem_wen), 32'd0);
    chk("async_stall", 32'(bus.pipe_stall), 32'd0);
    chk("async_ack", 32'(bus.host_ack), 32'd0);
    chk("async_rdata", bus.host_rdata, 32'h0);
    tick();
    @(negedge clk);
    chk("rst_hold_ack", 32'(bus.host_ack), 32'd0);
    tick();
    bus.pipe_mem_req = 1'b0;
    bus.pipe_wen     = 1'b0;
    rst_n            = 1'b1;
    last_rd          = 32'h0;
    ackq.push_back(mk(cyc + 2, last_rd, "rereq"));
    @(negedge clk);
    chk("rereq_idle_grant", 32'(bus.mem_wen), 32'd1);
    tick();
    tick();
    tick();
    bus.host_req = 1'b0;
    tick();

    bus.host_req = 1'b1;
    bus.host_wen = 1'b0;
    ackq.push_back(mk(cyc + 2, 32'hA5A5A5A5, "rdback"));
    tick();
    tick();
    tick();
    bus.host_req = 1'b0;

    for (int i = 0; i < 10; i++) begin
      if (ackq.size() == 0 && pipeq.size() == 0) break;
      tick();
    end
    if (ackq.size() != 0 || pipeq.size() != 0)
      chk("drain_timeout", 32'(ackq.size() + pipeq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
